// File: rtl/pc_gen_unit_if.sv
// Fetch-PC bundle: redirect/stall requests into the PC generator and the PC state it reports back.
interface pc_gen_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             stall_if;
  logic             trap_valid;
  logic [XLEN-1:0]  trap_target;
  logic             br_valid;
  logic [XLEN-1:0]  br_target;
  logic             jmp_valid;
  logic [XLEN-1:0]  jmp_target;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  pc_plus;
  logic [XLEN-1:0]  pc_next;
  logic             pc_valid;
  logic             misalign_err;
  logic [CNT_W-1:0] redirect_cnt;

  modport master (
    output stall_if, trap_valid, trap_target, br_valid, br_target, jmp_valid, jmp_target,
    input  pc, pc_plus, pc_next, pc_valid, misalign_err, redirect_cnt
  );

  modport slave (
    input  stall_if, trap_valid, trap_target, br_valid, br_target, jmp_valid, jmp_target,
    output pc, pc_plus, pc_next, pc_valid, misalign_err, redirect_cnt
  );
endinterface

// File: rtl/pc_gen_unit.sv
// IF-stage PC generator: trap > branch > jump > stall > PC+STEP, one-cycle redirect latency.
// No backpressure of its own; stall_if holds the PC and any redirect overrides the stall.
module pc_gen_unit #(
  parameter int          XLEN       = 32,
  parameter int          STEP       = 4,
  parameter logic [31:0] RESET_VEC  = 32'h0000_3000,
  parameter int          ALIGN_BITS = 2,
  parameter int          CNT_W      = 16
) (
  input logic         clk,
  input logic         rstn,
  pc_gen_unit_if.slave bus
);

  localparam logic [XLEN-1:0] RST_PC     = XLEN'(RESET_VEC);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~((XLEN'(1) << ALIGN_BITS) - XLEN'(1));

  logic [XLEN-1:0]  pc_q;
  logic             vld_q;
  logic             mis_q;
  logic [CNT_W-1:0] cnt_q;

  logic [XLEN-1:0]  pc_plus;
  logic [XLEN-1:0]  pc_next;
  logic [XLEN-1:0]  raw_target;
  logic             redirect;
  logic             mis_d;

  assign pc_plus = pc_q + XLEN'(STEP);

  // Requests are only honoured once the first fetch address is live.
  always_comb begin
    raw_target = bus.jmp_target;
    redirect   = 1'b0;
    mis_d      = 1'b0;
    pc_next    = pc_q;
    if (vld_q) begin
      redirect = bus.trap_valid | bus.br_valid | bus.jmp_valid;
      if (bus.trap_valid)    raw_target = bus.trap_target;
      else if (bus.br_valid) raw_target = bus.br_target;
      if (redirect) begin
        pc_next = raw_target & ALIGN_MASK;
        mis_d   = |(raw_target & ~ALIGN_MASK);
      end else if (!bus.stall_if) begin
        pc_next = pc_plus;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q  <= RST_PC;
      vld_q <= 1'b0;
      mis_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_next;
      vld_q <= 1'b1;
      mis_q <= mis_d;
      if (redirect && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.pc           = pc_q;
  assign bus.pc_plus      = pc_plus;
  assign bus.pc_next      = pc_next;
  assign bus.pc_valid     = vld_q;
  assign bus.misalign_err = mis_q;
  assign bus.redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed bench: default 32-bit instance plus an 8-bit/2-bit-counter instance for wrap and saturation.
module tb_pc_gen_unit;

  logic clk;
  logic rstn;
  logic rstn_s;

  int n_cmp;
  int n_err;

  pc_gen_unit_if #(.XLEN(32), .CNT_W(16)) bus ();
  pc_gen_unit_if #(.XLEN(8),  .CNT_W(2))  sbus ();

  pc_gen_unit dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  pc_gen_unit #(
    .XLEN(8), .STEP(4), .RESET_VEC(32'h0000_00F8), .ALIGN_BITS(2), .CNT_W(2)
  ) dut_s (
    .clk  (clk),
    .rstn (rstn_s),
    .bus  (sbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr_big();
    bus.stall_if    = 1'b0;
    bus.trap_valid  = 1'b0;
    bus.trap_target = '0;
    bus.br_valid    = 1'b0;
    bus.br_target   = '0;
    bus.jmp_valid   = 1'b0;
    bus.jmp_target  = '0;
  endtask

  initial begin
    logic [31:0] seq [4];
    seq[0] = 32'h3004; seq[1] = 32'h3008; seq[2] = 32'h300C; seq[3] = 32'h3010;
    n_cmp = 0;
    n_err = 0;
    rstn   = 1'b0;
    rstn_s = 1'b0;
    clr_big();
    sbus.stall_if    = 1'b0;
    sbus.trap_valid  = 1'b0;
    sbus.trap_target = '0;
    sbus.br_valid    = 1'b0;
    sbus.br_target   = '0;
    sbus.jmp_valid   = 1'b0;
    sbus.jmp_target  = '0;

    // Reset values, with a branch request that must be ignored during start-up
    bus.br_valid  = 1'b1;
    bus.br_target = 32'h4000;
    @(negedge clk);
    chk("rst_pc", bus.pc, 32'h3000);
    chk("rst_vld", {31'b0, bus.pc_valid}, 32'h0);
    chk("rst_mis", {31'b0, bus.misalign_err}, 32'h0);
    chk("rst_cnt", {16'b0, bus.redirect_cnt}, 32'h0);
    rstn = 1'b1;
    #1;
    chk("startup_pc_next", bus.pc_next, 32'h3000);
    @(negedge clk);
    chk("first_pc", bus.pc, 32'h3000);
    chk("first_vld", {31'b0, bus.pc_valid}, 32'h1);
    chk("first_cnt", {16'b0, bus.redirect_cnt}, 32'h0);
    bus.br_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("seq_pc", bus.pc, seq[i]);
    end
    chk("seq_pc_plus", bus.pc_plus, 32'h3014);

    // Stall three cycles at 0x3010
    bus.stall_if = 1'b1;
    #1;
    chk("stall_pc_next", bus.pc_next, 32'h3010);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_hold", bus.pc, 32'h3010);
    end
    bus.stall_if = 1'b0;
    @(negedge clk);
    chk("stall_release", bus.pc, 32'h3014);

    // Branch beats jump, redirect beats stall, counts once
    bus.br_valid   = 1'b1;
    bus.br_target  = 32'h3100;
    bus.jmp_valid  = 1'b1;
    bus.jmp_target = 32'h3200;
    bus.stall_if   = 1'b1;
    #1;
    chk("br_jmp_pc_next", bus.pc_next, 32'h3100);
    @(negedge clk);
    chk("br_jmp_pc", bus.pc, 32'h3100);
    chk("br_jmp_cnt", {16'b0, bus.redirect_cnt}, 32'h1);
    chk("br_jmp_mis", {31'b0, bus.misalign_err}, 32'h0);

    // Trap beats branch
    clr_big();
    bus.trap_valid  = 1'b1;
    bus.trap_target = 32'h1C08;
    bus.br_valid    = 1'b1;
    bus.br_target   = 32'h3300;
    @(negedge clk);
    chk("trap_pc", bus.pc, 32'h1C08);
    chk("trap_cnt", {16'b0, bus.redirect_cnt}, 32'h2);

    // Misaligned jump target is forced aligned and flagged for one cycle
    clr_big();
    bus.jmp_valid  = 1'b1;
    bus.jmp_target = 32'h3202;
    @(negedge clk);
    chk("mis_pc", bus.pc, 32'h3200);
    chk("mis_pulse", {31'b0, bus.misalign_err}, 32'h1);
    chk("mis_cnt", {16'b0, bus.redirect_cnt}, 32'h3);
    clr_big();
    @(negedge clk);
    chk("mis_clear", {31'b0, bus.misalign_err}, 32'h0);
    chk("after_mis_pc", bus.pc, 32'h3204);

    // Asynchronous reset mid-run with a branch pending
    bus.br_valid  = 1'b1;
    bus.br_target = 32'h5000;
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_pc", bus.pc, 32'h3000);
    chk("arst_vld", {31'b0, bus.pc_valid}, 32'h0);
    chk("arst_cnt", {16'b0, bus.redirect_cnt}, 32'h0);
    chk("arst_mis", {31'b0, bus.misalign_err}, 32'h0);
    clr_big();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("restart_pc0", bus.pc, 32'h3000);
    chk("restart_vld", {31'b0, bus.pc_valid}, 32'h1);
    @(negedge clk);
    chk("restart_pc1", bus.pc, 32'h3004);

    // 8-bit instance: wrap past 0xFC, then counter saturation at 3
    rstn_s = 1'b1;
    @(negedge clk);
    chk("s_pc0", {24'b0, sbus.pc}, 32'hF8);
    chk("s_vld", {31'b0, sbus.pc_valid}, 32'h1);
    @(negedge clk);
    chk("s_pc1", {24'b0, sbus.pc}, 32'hFC);
    chk("s_pc_plus_wrap", {24'b0, sbus.pc_plus}, 32'h00);
    @(negedge clk);
    chk("s_pc_wrap", {24'b0, sbus.pc}, 32'h00);
    chk("s_wrap_mis", {31'b0, sbus.misalign_err}, 32'h0);
    sbus.jmp_valid  = 1'b1;
    sbus.jmp_target = 8'h40;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("s_sat_cnt", {30'b0, sbus.redirect_cnt}, (i < 3) ? i : 3);
    end
    chk("s_jmp_pc", {24'b0, sbus.pc}, 32'h40);
    sbus.jmp_valid = 1'b0;
    @(negedge clk);
    chk("s_after_pc", {24'b0, sbus.pc}, 32'h44);
    chk("s_after_cnt", {30'b0, sbus.redirect_cnt}, 32'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
